// File: rtl/codec_i2c_pkg.sv
// Shared types and constants for the codec control-port I2C responder:
// FSM state encoding, register file size and the codec's power-on values.
package codec_i2c_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      ACK_A,
      BYTE1,
      ACK_1,
      BYTE2,
      ACK_2,
      IGNORE
   } state_t;

   localparam int         REG_COUNT = 10;
   localparam logic [6:0] RESET_REG = 7'h0F;

   // Power-on contents of R0..R9; also restored by a write to RESET_REG.
   localparam logic [8:0] REG_DEFAULTS [REG_COUNT] = '{
      9'h097, 9'h097, 9'h079, 9'h079, 9'h00A,
      9'h008, 9'h09F, 9'h00A, 9'h000, 9'h000
   };

endpackage

// File: rtl/i2c_bus_cond.sv
// SCL/SDA conditioning: synchronizer, optional 3-sample majority filter
// (CODEC_I2C_RESPONDER_GLITCH_FILTER_EN), then registered SCL edge and
// START/STOP events. Every event is valid for exactly one clk.
module i2c_bus_cond #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic i2c_clk,
   input  logic i2c_dat,
   output logic sda_bit,
   output logic scl_rise,
   output logic scl_fall,
   output logic start,
   output logic stop
);

   logic [SYNC_STAGES-1:0] scl_sync;
   logic [SYNC_STAGES-1:0] sda_sync;
   logic                   scl_cur;
   logic                   sda_cur;
   logic                   scl_prev;
   logic                   sda_prev;

   // Metastability synchronizer; resets to the idle (released) bus level.
   always_ff @(posedge clk) begin
      if (!reset) begin
         scl_sync <= '1;
         sda_sync <= '1;
      end else begin
         scl_sync <= {scl_sync[SYNC_STAGES-2:0], i2c_clk};
         sda_sync <= {sda_sync[SYNC_STAGES-2:0], i2c_dat};
      end
   end

`ifdef CODEC_I2C_RESPONDER_GLITCH_FILTER_EN
   logic [1:0] scl_hist;
   logic [1:0] sda_hist;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   // Majority of the current and two previous samples: a single-clk pulse never wins.
   always_ff @(posedge clk) begin
      if (!reset) begin
         scl_hist <= '1;
         sda_hist <= '1;
         scl_cur  <= 1'b1;
         sda_cur  <= 1'b1;
      end else begin
         scl_hist <= {scl_hist[0], scl_sync[SYNC_STAGES-1]};
         sda_hist <= {sda_hist[0], sda_sync[SYNC_STAGES-1]};
         scl_cur  <= maj3(scl_sync[SYNC_STAGES-1], scl_hist[0], scl_hist[1]);
         sda_cur  <= maj3(sda_sync[SYNC_STAGES-1], sda_hist[0], sda_hist[1]);
      end
   end
`else
   assign scl_cur = scl_sync[SYNC_STAGES-1];
   assign sda_cur = sda_sync[SYNC_STAGES-1];
`endif

   // Edge detect; events are registered so the FSM acts one clk after the edge.
   always_ff @(posedge clk) begin
      if (!reset) begin
         scl_prev <= 1'b1;
         sda_prev <= 1'b1;
         sda_bit  <= 1'b1;
         scl_rise <= 1'b0;
         scl_fall <= 1'b0;
         start    <= 1'b0;
         stop     <= 1'b0;
      end else begin
         scl_prev <= scl_cur;
         sda_prev <= sda_cur;
         sda_bit  <= sda_cur;
         scl_rise <= scl_cur & ~scl_prev;
         scl_fall <= ~scl_cur & scl_prev;
         start    <= scl_cur & scl_prev & sda_prev & ~sda_cur;
         stop     <= scl_cur & scl_prev & ~sda_prev & sda_cur;
      end
   end

endmodule

// File: rtl/codec_i2c_responder.sv
// I2C target modelling the audio codec's write-only control port.
// Frame: address byte, {reg[6:0], data[8]}, data[7:0]; commits to a 16 x 9
// register space of which R0..R9 are stored. Optional input glitch filter:
// CODEC_I2C_RESPONDER_GLITCH_FILTER_EN.
module codec_i2c_responder
   import codec_i2c_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR    = 7'h1A,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i2c_clk,
   input  logic       i2c_dat_i,
   output logic       i2c_dat_oe,
   input  logic [3:0] rd_idx,
   output logic [8:0] rd_data,
   output logic       wr_strobe,
   output logic [6:0] wr_idx,
   output logic [8:0] wr_data,
   output logic       busy
);

   logic       sda_bit, scl_rise, scl_fall, start, stop;
   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [7:0] shreg_q, shreg_d;
   logic [7:0] byte1_q, byte1_d;
   logic       oe_q, oe_d;
   logic       commit;
   logic [6:0] commit_reg;
   logic [8:0] commit_data;
   logic [8:0] regs [REG_COUNT];

   i2c_bus_cond #(.SYNC_STAGES(SYNC_STAGES)) u_bus_cond (
      .clk      (clk),
      .reset    (reset),
      .i2c_clk  (i2c_clk),
      .i2c_dat  (i2c_dat_i),
      .sda_bit  (sda_bit),
      .scl_rise (scl_rise),
      .scl_fall (scl_fall),
      .start    (start),
      .stop     (stop)
   );

   assign commit_reg  = byte1_q[7:1];
   assign commit_data = {byte1_q[0], shreg_q};

   // Next-state logic: STOP/START override everything, bits shift on SCL
   // rise, byte decisions and ACK release happen on SCL fall.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shreg_d = shreg_q;
      byte1_d = byte1_q;
      oe_d    = oe_q;
      commit  = 1'b0;
      if (stop) begin
         state_d = IDLE;
         oe_d    = 1'b0;
         cnt_d   = '0;
      end else if (start) begin
         state_d = ADDR;
         oe_d    = 1'b0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ADDR, BYTE1, BYTE2: begin
               if (scl_rise && cnt_q != 4'd8) begin
                  shreg_d = {shreg_q[6:0], sda_bit};
                  cnt_d   = cnt_q + 4'd1;
               end else if (scl_fall && cnt_q == 4'd8) begin
                  cnt_d = '0;
                  case (state_q)
                     ADDR: begin
                        // Only a write to our address is ACKed; reads are NACKed.
                        if (shreg_q == {DEV_ADDR, 1'b0}) begin
                           oe_d    = 1'b1;
                           state_d = ACK_A;
                        end else begin
                           state_d = IGNORE;
                        end
                     end
                     BYTE1: begin
                        byte1_d = shreg_q;
                        oe_d    = 1'b1;
                        state_d = ACK_1;
                     end
                     default: begin
                        commit  = 1'b1;
                        oe_d    = 1'b1;
                        state_d = ACK_2;
                     end
                  endcase
               end
            end
            ACK_A, ACK_1, ACK_2: begin
               // Entered on a fall, so the next fall ends the ACK clock period.
               if (scl_fall) begin
                  oe_d = 1'b0;
                  case (state_q)
                     ACK_A:   state_d = BYTE1;
                     ACK_1:   state_d = BYTE2;
                     default: state_d = IGNORE;
                  endcase
               end
            end
            default: ;
         endcase
      end
   end

   // FSM and shift-path registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         shreg_q <= '0;
         byte1_q <= '0;
         oe_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shreg_q <= shreg_d;
         byte1_q <= byte1_d;
         oe_q    <= oe_d;
      end
   end

   // Commit report: one-clk strobe plus the last committed address and data.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_strobe <= 1'b0;
         wr_idx    <= '0;
         wr_data   <= '0;
      end else begin
         wr_strobe <= commit;
         if (commit) begin
            wr_idx  <= commit_reg;
            wr_data <= commit_data;
         end
      end
   end

   // Register file: RESET_REG reloads defaults, other out-of-range addresses are dropped.
   always_ff @(posedge clk) begin
      if (!reset || (commit && commit_reg == RESET_REG)) begin
         regs <= REG_DEFAULTS;
      end else if (commit && commit_reg < 7'(REG_COUNT)) begin
         regs[commit_reg[3:0]] <= commit_data;
      end
   end

   assign rd_data    = (rd_idx < 4'(REG_COUNT)) ? regs[rd_idx] : '0;
   assign i2c_dat_oe = oe_q;
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_codec_i2c_responder.sv
// Directed bench for codec_i2c_responder: a table of write frames with
// hand-computed ACK pattern, commit report and register readback, plus
// hand-written repeated-start and reset-mid-frame sequences.
module tb_codec_i2c_responder;

   localparam int H = 12;  // SCL half-period in clk
   localparam int Q = 6;   // SDA setup point inside the low phase

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       scl = 1'b1;
   logic       sda_drv = 1'b1;
   logic       i2c_dat_i;
   logic       i2c_dat_oe;
   logic [3:0] rd_idx = '0;
   logic [8:0] rd_data;
   logic       wr_strobe;
   logic [6:0] wr_idx;
   logic [8:0] wr_data;
   logic       busy;

   // Open-drain bus: either side can pull SDA low.
   assign i2c_dat_i = sda_drv & ~i2c_dat_oe;

   always #5 clk = ~clk;

   codec_i2c_responder dut (
      .clk        (clk),
      .reset      (reset),
      .i2c_clk    (scl),
      .i2c_dat_i  (i2c_dat_i),
      .i2c_dat_oe (i2c_dat_oe),
      .rd_idx     (rd_idx),
      .rd_data    (rd_data),
      .wr_strobe  (wr_strobe),
      .wr_idx     (wr_idx),
      .wr_data    (wr_data),
      .busy       (busy)
   );

   int checks   = 0;
   int failures = 0;

   // Codec power-on values, written out independently of the design package.
   logic [8:0] defaults [10] = '{9'h097, 9'h097, 9'h079, 9'h079, 9'h00A,
                                 9'h008, 9'h09F, 9'h00A, 9'h000, 9'h000};

   // Strobe monitor: counts commits, records the last report, flags wide pulses.
   int         strobe_cnt = 0;
   int         wide_cnt   = 0;
   logic       strobe_prev = 1'b0;
   logic [6:0] last_idx = '0;
   logic [8:0] last_data = '0;
   always @(negedge clk) begin
      if (wr_strobe) begin
         strobe_cnt++;
         last_idx  = wr_idx;
         last_data = wr_data;
         if (strobe_prev) wide_cnt++;
      end
      strobe_prev = wr_strobe;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic i2c_start();
      sda_drv = 1'b1;
      wait_clk(Q);
      scl = 1'b1;
      wait_clk(H);
      sda_drv = 1'b0;
      wait_clk(H);
      scl = 1'b0;
   endtask

   task automatic i2c_stop();
      wait_clk(Q);
      sda_drv = 1'b0;
      wait_clk(Q);
      scl = 1'b1;
      wait_clk(H);
      sda_drv = 1'b1;
      wait_clk(H);
   endtask

   task automatic i2c_bit(input logic b);
      wait_clk(Q);
      sda_drv = b;
      wait_clk(Q);
      scl = 1'b1;
      wait_clk(H);
      scl = 1'b0;
   endtask

   task automatic i2c_byte(input logic [7:0] b, output logic ack);
      for (int i = 7; i >= 0; i--) i2c_bit(b[i]);
      wait_clk(Q);
      sda_drv = 1'b1;
      wait_clk(Q);
      scl = 1'b1;
      wait_clk(Q);
      ack = ~i2c_dat_i;
      wait_clk(Q);
      scl = 1'b0;
   endtask

   typedef struct {
      int          n;
      logic [31:0] bytes;   // byte k at [31-8k -: 8]
      logic [3:0]  acks;    // bit k = ACK expected for byte k
      int          strobes;
      logic [6:0]  idx;
      logic [8:0]  data;
      logic [3:0]  rdi;
      logic [8:0]  rdd;
   } vec_t;

   function automatic vec_t mk(input int n, input logic [31:0] bytes, input logic [3:0] acks,
                               input int strobes, input logic [6:0] idx, input logic [8:0] data,
                               input logic [3:0] rdi, input logic [8:0] rdd);
      vec_t v;
      v.n = n; v.bytes = bytes; v.acks = acks; v.strobes = strobes;
      v.idx = idx; v.data = data; v.rdi = rdi; v.rdd = rdd;
      return v;
   endfunction

   vec_t vecs [9];

   initial begin
      logic ack;
      int   s0;

      vecs[0] = mk(3, 32'h34_08_12_00, 4'b0111, 1, 7'h04, 9'h012, 4'd4, 9'h012);
      vecs[1] = mk(3, 32'h36_08_55_00, 4'b0000, 0, 7'h00, 9'h000, 4'd4, 9'h012);
      vecs[2] = mk(2, 32'h35_FF_00_00, 4'b0000, 0, 7'h00, 9'h000, 4'd3, 9'h079);
      vecs[3] = mk(2, 32'h34_0C_00_00, 4'b0011, 0, 7'h00, 9'h000, 4'd6, 9'h09F);
      vecs[4] = mk(3, 32'h34_05_FF_00, 4'b0111, 1, 7'h02, 9'h1FF, 4'd2, 9'h1FF);
      vecs[5] = mk(3, 32'h34_1E_00_00, 4'b0111, 1, 7'h0F, 9'h000, 4'd2, 9'h079);
      vecs[6] = mk(3, 32'h34_15_34_00, 4'b0111, 1, 7'h0A, 9'h134, 4'd4, 9'h00A);
      vecs[7] = mk(4, 32'h34_12_AB_CD, 4'b0111, 1, 7'h09, 9'h0AB, 4'd9, 9'h0AB);
      vecs[8] = mk(3, 32'h34_01_5A_00, 4'b0111, 1, 7'h00, 9'h15A, 4'd0, 9'h15A);

      // Reset state.
      reset = 1'b0;
      wait_clk(5);
      check("reset_oe", 32'(i2c_dat_oe), 32'h0);
      check("reset_strobe", 32'(wr_strobe), 32'h0);
      check("reset_wr_idx", 32'(wr_idx), 32'h0);
      check("reset_wr_data", 32'(wr_data), 32'h0);
      check("reset_busy", 32'(busy), 32'h0);
      for (int i = 0; i < 10; i++) begin
         rd_idx = 4'(i);
         #1;
         check($sformatf("reset_reg%0d", i), 32'(rd_data), 32'(defaults[i]));
      end
      reset = 1'b1;
      wait_clk(4);

      // Table-driven frames.
      for (int v = 0; v < 9; v++) begin
         s0 = strobe_cnt;
         i2c_start();
         for (int k = 0; k < vecs[v].n; k++) begin
            i2c_byte(vecs[v].bytes[31-8*k -: 8], ack);
            check($sformatf("v%0d_ack%0d", v, k), 32'(ack), 32'(vecs[v].acks[k]));
         end
         check($sformatf("v%0d_busy_in_frame", v), 32'(busy), 32'h1);
         i2c_stop();
         check($sformatf("v%0d_busy_after_stop", v), 32'(busy), 32'h0);
         check($sformatf("v%0d_oe_idle", v), 32'(i2c_dat_oe), 32'h0);
         check($sformatf("v%0d_strobes", v), 32'(strobe_cnt - s0), 32'(vecs[v].strobes));
         if (vecs[v].strobes != 0) begin
            check($sformatf("v%0d_wr_idx", v), 32'(last_idx), 32'(vecs[v].idx));
            check($sformatf("v%0d_wr_data", v), 32'(last_data), 32'(vecs[v].data));
         end
         rd_idx = vecs[v].rdi;
         #1;
         check($sformatf("v%0d_rd_data", v), 32'(rd_data), 32'(vecs[v].rdd));
      end

      // Repeated START abandons a partial frame; only the second frame commits.
      s0 = strobe_cnt;
      i2c_start();
      i2c_byte(8'h34, ack);
      i2c_byte(8'h08, ack);
      i2c_start();
      i2c_byte(8'h34, ack);
      check("rs_ack_addr", 32'(ack), 32'h1);
      i2c_byte(8'h0E, ack);
      i2c_byte(8'h33, ack);
      check("rs_ack_data", 32'(ack), 32'h1);
      i2c_stop();
      check("rs_strobes", 32'(strobe_cnt - s0), 32'h1);
      check("rs_wr_idx", 32'(last_idx), 32'h07);
      check("rs_wr_data", 32'(last_data), 32'h033);
      rd_idx = 4'd7;
      #1;
      check("rs_reg7", 32'(rd_data), 32'h033);
      rd_idx = 4'd4;
      #1;
      check("rs_reg4_untouched", 32'(rd_data), 32'h00A);

      // Reset while the responder drives the byte-1 ACK.
      s0 = strobe_cnt;
      i2c_start();
      i2c_byte(8'h34, ack);
      for (int i = 7; i >= 0; i--) i2c_bit(1'(8'h08 >> i));
      wait_clk(Q);
      check("mid_oe_before_reset", 32'(i2c_dat_oe), 32'h1);
      reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("mid_oe_after_reset", 32'(i2c_dat_oe), 32'h0);
      check("mid_busy_after_reset", 32'(busy), 32'h0);
      check("mid_wr_idx_after_reset", 32'(wr_idx), 32'h0);
      rd_idx = 4'd0;
      #1;
      check("mid_reg0_reloaded", 32'(rd_data), 32'h097);
      reset = 1'b1;
      sda_drv = 1'b1;
      wait_clk(Q);
      scl = 1'b1;
      wait_clk(H);
      check("mid_no_strobe", 32'(strobe_cnt - s0), 32'h0);

      // Next full frame after the reset is accepted normally.
      s0 = strobe_cnt;
      i2c_start();
      i2c_byte(8'h34, ack);
      check("post_ack_addr", 32'(ack), 32'h1);
      i2c_byte(8'h08, ack);
      check("post_ack_b1", 32'(ack), 32'h1);
      i2c_byte(8'h12, ack);
      check("post_ack_b2", 32'(ack), 32'h1);
      i2c_stop();
      check("post_strobes", 32'(strobe_cnt - s0), 32'h1);
      check("post_wr_idx", 32'(last_idx), 32'h04);
      check("post_wr_data", 32'(last_data), 32'h012);
      rd_idx = 4'd4;
      #1;
      check("post_reg4", 32'(rd_data), 32'h012);

      check("strobe_width", 32'(wide_cnt), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
